execute_datapath: RTL and testbench
===================================

Name: execute_datapath

Overview:
Datapath stage directly downstream of the fetch/control integration (PC, memory, IR, control).
- Consumes IR, PC, memory read data and the control signals.
- Holds ACC, SP, MDR, ALUOut and the output-port register; contains sign/zero extension, the ALU operand muxes, the ALU and branch evaluation.
- Returns ALUOut, SPOut, next-PC (PCin), DoBranch and memory write data (din) to the fetch stage.

Parameters:
SP_INIT, 16'h03FE, SP value after reset.
OUT_INIT, 16'h0000, OutPort value after reset.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
IROut  input  16  instruction register; IROut[7:0] is the immediate.
PCOut  input  16  current PC.
DataOut  input  16  memory read data.
InPort  input  16  external input word.
MemOutWrite  input  1  load MDR from DataOut.
ACCWrite  input  1  load ACC.
SPWrite  input  1  load SP.
SignExt  input  1  1 = sign-extend imm, 0 = zero-extend.
ALUSrcA  input  2  A select: 0 PC, 1 ACC, 2 SP, 3 MDR.
ALUSrcB  input  2  B select: 0 imm16, 1 16'd1, 2 MDR, 3 ACC.
ALUOp  input  3  0 add, 1 sub (A-B), 2 and, 3 or, 4 xor, 5 A<<1, 6 A>>>1 (arithmetic), 7 pass B.
ACCSrc  input  2  0 ALUOut reg, 1 MDR, 2 imm16, 3 InPort.
SPSrc  input  1  0 ALUOut reg, 1 ALU result (combinational).
PCSrc  input  2  0 ALU result, 1 ALUOut reg, 2 {PCOut[15:8],IROut[7:0]}, 3 MDR.
BranchCond  input  2  0 ACC==0, 1 ACC!=0, 2 ACC[15]==1, 3 always.
BranchCycle  input  1  branch-evaluation cycle.
MemData  input  1  din select: 0 ACC, 1 PCOut.
OutWrite  input  1  load OutPort from ACC.
ALUOut  output  16  registered ALU result.
SPOut  output  16  stack pointer.
ACCOut  output  16  accumulator.
PCin  output  16  next-PC value to PC register.
DoBranch  output  1  branch taken this cycle.
din  output  16  memory write data.
OutPort  output  16  output-port register.

Behaviour:
- Reset values: ALUOut 0, ACC 0, MDR 0, SP SP_INIT, OutPort OUT_INIT.
  - Reset has priority over every write enable in the same cycle.
  - Reset mid-instruction discards all pending writes.
- imm16: SignExt=1 → {{8{IROut[7]}},IROut[7:0]}; SignExt=0 → {8'h00,IROut[7:0]}.
- ALU is combinational; all arithmetic is modulo 2^16 with no carry/overflow outputs.
- Shifts use A only: shl fills 0; shr replicates bit 15.
- ALUOut register loads the ALU result on every non-reset edge (no enable), so the result is available one cycle after operand presentation.
- MDR loads DataOut when MemOutWrite=1; otherwise holds.
- ACC, SP, OutPort load only when their enable is 1.
  - Sources are sampled pre-edge: ACCSrc=0 writes the ALUOut value from before this edge, not the concurrent ALU result.
- SPSrc=1 allows single-cycle push/pop: SP <= ALU result at the same edge.
- DoBranch = BranchCycle & cond(BranchCond), combinational.
  - Evaluated on pre-edge ACC; an ACCWrite in the same cycle does not affect it.
  - DoBranch=0 whenever BranchCycle=0, and during reset.
- PCin and din are combinational muxes; no latency.
- Simultaneous writes: ACCWrite with OutWrite stores the old ACC in OutPort. SPWrite with ALUSrcA=2 uses the old SP as operand.
- Undriven/illegal encodings do not exist: all 2- and 3-bit codes are defined above.

Test Plan:
1. reset=1 for 2 cycles with all write enables high → ALUOut=0, ACC=0, SP=16'h03FE, OutPort=0, DoBranch=0.
2. Immediate extension: IROut=16'h22F0, SignExt=1, ACCSrc=2, ACCWrite → ACC=16'hFFF0; repeat with SignExt=0 → ACC=16'h00F0.
3. ALU sweep with A=ACC=16'h8001, B=MDR=16'h0003 → ALUOut next cycle:
   - add 8004, sub 7FFE, and 0001, or 8003, xor 8002, shl 0002, shr C000, passB 0003.
   - add of FFFF+0001 wraps to 0000.
4. Push: SP=03FE, ALUSrcA=2, ALUSrcB=1, ALUOp=1, SPSrc=1, SPWrite, MemData=1, PCOut=0123 → SP=03FD after edge; din=0123 during the cycle.
5. Branches with BranchCycle=1:
   - ACC=0, BranchCond=0 → DoBranch=1.
   - ACC=0, BranchCond=1 → DoBranch=0.
   - ACC=8000, BranchCond=2 → DoBranch=1.
   - BranchCycle=0, BranchCond=3 → DoBranch=0.
   - ACC=0 with ACCWrite loading 5 in the same cycle, BranchCond=0 → DoBranch=1.
6. PCin sources: PCSrc=2 with PCOut=1234, IR[7:0]=56 → PCin=1256; PCSrc=3 with MDR=BEEF → PCin=BEEF. Assert reset while ACCWrite=1 → ACC=0.

Source files
------------

// File: rtl/execute_datapath.sv
// Execute datapath: accumulator/stack datapath behind fetch/control.
// Holds ACC, SP, MDR, ALUOut and OutPort. Extends the immediate, selects ALU
// operands and evaluates branches. Feeds next-PC, SP and write data back to fetch.
module execute_datapath #(
  parameter logic [15:0] SP_INIT  = 16'h03FE,
  parameter logic [15:0] OUT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IROut,
  input  logic [15:0] PCOut,
  input  logic [15:0] DataOut,
  input  logic [15:0] InPort,
  input  logic        MemOutWrite,
  input  logic        ACCWrite,
  input  logic        SPWrite,
  input  logic        SignExt,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [2:0]  ALUOp,
  input  logic [1:0]  ACCSrc,
  input  logic        SPSrc,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  BranchCond,
  input  logic        BranchCycle,
  input  logic        MemData,
  input  logic        OutWrite,
  output logic [15:0] ALUOut,
  output logic [15:0] SPOut,
  output logic [15:0] ACCOut,
  output logic [15:0] PCin,
  output logic        DoBranch,
  output logic [15:0] din,
  output logic [15:0] OutPort
);

  logic [15:0] aluout_q, acc_q, mdr_q, sp_q, out_q;
  logic [15:0] aluout_d, acc_d, mdr_d, sp_d, out_d;
  logic [15:0] imm16, op_a, op_b, alu_res;
  logic        cond;

  // Only the low byte of IR is consumed here; the opcode byte is decoded upstream.
  logic unused_ir;
  assign unused_ir = ^IROut[15:8];

  assign imm16 = SignExt ? {{8{IROut[7]}}, IROut[7:0]} : {8'h00, IROut[7:0]};

  // Operand muxes and ALU; everything wraps modulo 2^16.
  always_comb begin
    op_a = PCOut;
    case (ALUSrcA)
      2'd0: op_a = PCOut;
      2'd1: op_a = acc_q;
      2'd2: op_a = sp_q;
      2'd3: op_a = mdr_q;
    endcase
    op_b = imm16;
    case (ALUSrcB)
      2'd0: op_b = imm16;
      2'd1: op_b = 16'd1;
      2'd2: op_b = mdr_q;
      2'd3: op_b = acc_q;
    endcase
    alu_res = '0;
    case (ALUOp)
      3'd0: alu_res = op_a + op_b;
      3'd1: alu_res = op_a - op_b;
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res = {op_a[14:0], 1'b0};
      3'd6: alu_res = {op_a[15], op_a[15:1]};
      3'd7: alu_res = op_b;
    endcase
  end

  // Branch condition on the pre-edge ACC; forced low outside branch cycles and in reset.
  always_comb begin
    cond = 1'b1;
    case (BranchCond)
      2'd0: cond = (acc_q == 16'd0);
      2'd1: cond = (acc_q != 16'd0);
      2'd2: cond = acc_q[15];
      2'd3: cond = 1'b1;
    endcase
    DoBranch = BranchCycle & cond & ~reset;
  end

  // Next-PC and memory write-data selection, no latency.
  always_comb begin
    PCin = alu_res;
    case (PCSrc)
      2'd0: PCin = alu_res;
      2'd1: PCin = aluout_q;
      2'd2: PCin = {PCOut[15:8], IROut[7:0]};
      2'd3: PCin = mdr_q;
    endcase
    din = MemData ? PCOut : acc_q;
  end

  // Next-state selection; every source is a pre-edge value.
  always_comb begin
    aluout_d = alu_res;
    mdr_d    = MemOutWrite ? DataOut : mdr_q;
    acc_d    = acc_q;
    if (ACCWrite) begin
      case (ACCSrc)
        2'd0: acc_d = aluout_q;
        2'd1: acc_d = mdr_q;
        2'd2: acc_d = imm16;
        2'd3: acc_d = InPort;
      endcase
    end
    sp_d  = SPWrite ? (SPSrc ? alu_res : aluout_q) : sp_q;
    out_d = OutWrite ? acc_q : out_q;
  end

  // State registers; reset overrides every write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluout_q <= '0;
      acc_q    <= '0;
      mdr_q    <= '0;
      sp_q     <= SP_INIT;
      out_q    <= OUT_INIT;
    end else begin
      aluout_q <= aluout_d;
      acc_q    <= acc_d;
      mdr_q    <= mdr_d;
      sp_q     <= sp_d;
      out_q    <= out_d;
    end
  end

  assign ALUOut  = aluout_q;
  assign SPOut   = sp_q;
  assign ACCOut  = acc_q;
  assign OutPort = out_q;

endmodule

// File: tb/tb_execute_datapath.sv
// Bench for execute_datapath: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the datapath.
module tb_execute_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] IROut, PCOut, DataOut, InPort;
  logic        MemOutWrite, ACCWrite, SPWrite, SignExt, SPSrc, BranchCycle, MemData, OutWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ACCSrc, PCSrc, BranchCond;
  logic [2:0]  ALUOp;
  logic [15:0] ALUOut, SPOut, ACCOut, PCin, din, OutPort;
  logic        DoBranch;

  execute_datapath dut (
    .clk(clk), .reset(reset), .IROut(IROut), .PCOut(PCOut), .DataOut(DataOut),
    .InPort(InPort), .MemOutWrite(MemOutWrite), .ACCWrite(ACCWrite), .SPWrite(SPWrite),
    .SignExt(SignExt), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ACCSrc(ACCSrc), .SPSrc(SPSrc), .PCSrc(PCSrc), .BranchCond(BranchCond),
    .BranchCycle(BranchCycle), .MemData(MemData), .OutWrite(OutWrite),
    .ALUOut(ALUOut), .SPOut(SPOut), .ACCOut(ACCOut), .PCin(PCin),
    .DoBranch(DoBranch), .din(din), .OutPort(OutPort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_alu, m_acc, m_mdr, m_sp, m_out;  // architectural state, 0..65535

  function automatic int imm_of();
    int v = int'(IROut[7:0]);
    if (SignExt && v >= 128) v = v - 256 + 65536;
    return v;
  endfunction

  function automatic int alu_of();
    int a, b, r;
    case (ALUSrcA)
      2'd0: a = int'(PCOut);
      2'd1: a = m_acc;
      2'd2: a = m_sp;
      default: a = m_mdr;
    endcase
    case (ALUSrcB)
      2'd0: b = imm_of();
      2'd1: b = 1;
      2'd2: b = m_mdr;
      default: b = m_acc;
    endcase
    case (ALUOp)
      3'd0: r = a + b;
      3'd1: r = a - b + 65536;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a * 2;
      3'd6: r = (a / 2) + (a >= 32768 ? 32768 : 0);
      default: r = b;
    endcase
    return r % 65536;
  endfunction

  function automatic bit br_of();
    bit c;
    case (BranchCond)
      2'd0: c = (m_acc == 0);
      2'd1: c = (m_acc != 0);
      2'd2: c = (m_acc >= 32768);
      default: c = 1'b1;
    endcase
    return BranchCycle && c && !reset;
  endfunction

  function automatic int pcin_of();
    case (PCSrc)
      2'd0: return alu_of();
      2'd1: return m_alu;
      2'd2: return (int'(PCOut) / 256) * 256 + int'(IROut[7:0]);
      default: return m_mdr;
    endcase
  endfunction

  // Model state advances at each rising edge from the pre-edge values.
  always @(posedge clk) begin
    int n_alu, n_acc, n_mdr, n_sp, n_out;
    if (reset) begin
      n_alu = 0; n_acc = 0; n_mdr = 0; n_sp = 16'h03FE; n_out = 0;
    end else begin
      n_alu = alu_of();
      n_mdr = MemOutWrite ? int'(DataOut) : m_mdr;
      n_acc = m_acc;
      if (ACCWrite)
        case (ACCSrc)
          2'd0: n_acc = m_alu;
          2'd1: n_acc = m_mdr;
          2'd2: n_acc = imm_of();
          default: n_acc = int'(InPort);
        endcase
      n_sp  = SPWrite ? (SPSrc ? alu_of() : m_alu) : m_sp;
      n_out = OutWrite ? m_acc : m_out;
    end
    m_alu = n_alu; m_acc = n_acc; m_mdr = n_mdr; m_sp = n_sp; m_out = n_out;
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ALUOut",   ALUOut,  16'(m_alu));
      chk("m_ACCOut",   ACCOut,  16'(m_acc));
      chk("m_SPOut",    SPOut,   16'(m_sp));
      chk("m_OutPort",  OutPort, 16'(m_out));
      chk("m_PCin",     PCin,    16'(pcin_of()));
      chk("m_din",      din,     MemData ? PCOut : 16'(m_acc));
      chk("m_DoBranch", {15'd0, DoBranch}, {15'd0, br_of()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; IROut = 0; PCOut = 0; DataOut = 0; InPort = 0;
    MemOutWrite = 0; ACCWrite = 0; SPWrite = 0; SignExt = 0; SPSrc = 0;
    BranchCycle = 0; MemData = 0; OutWrite = 0;
    ALUSrcA = 0; ALUSrcB = 0; ACCSrc = 0; PCSrc = 0; BranchCond = 0; ALUOp = 0;
  endtask

  task automatic load_acc(input logic [15:0] v);
    ACCWrite = 1; ACCSrc = 3; InPort = v;
    tick();
    ACCWrite = 0;
  endtask

  logic [15:0] sweep_exp [8] = '{16'h8004, 16'h7FFE, 16'h0001, 16'h8003,
                                 16'h8002, 16'h0002, 16'hC000, 16'h0003};

  initial begin
    idle();
    // Reset with every enable asserted.
    reset = 1; MemOutWrite = 1; ACCWrite = 1; SPWrite = 1; OutWrite = 1;
    BranchCycle = 1; BranchCond = 3; InPort = 16'h1111; ACCSrc = 3;
    tick();
    chk_en = 1'b1;
    tick();
    #1;
    chk("rst_ALUOut", ALUOut, 16'h0000);
    chk("rst_ACC", ACCOut, 16'h0000);
    chk("rst_SP", SPOut, 16'h03FE);
    chk("rst_Out", OutPort, 16'h0000);
    chk("rst_DoBranch", {15'd0, DoBranch}, 16'd0);
    idle();

    // Immediate extension.
    IROut = 16'h22F0; SignExt = 1; ACCSrc = 2; ACCWrite = 1;
    tick();
    chk("imm_sext", ACCOut, 16'hFFF0);
    SignExt = 0;
    tick();
    chk("imm_zext", ACCOut, 16'h00F0);
    idle();

    // ALU sweep, A=ACC=8001, B=MDR=0003.
    DataOut = 16'h0003; MemOutWrite = 1;
    load_acc(16'h8001);
    MemOutWrite = 0;
    ALUSrcA = 1; ALUSrcB = 2;
    for (int op = 0; op < 8; op++) begin
      ALUOp = 3'(op);
      tick();
      chk($sformatf("alu_op%0d", op), ALUOut, sweep_exp[op]);
    end
    DataOut = 16'h0001; MemOutWrite = 1;
    load_acc(16'hFFFF);
    MemOutWrite = 0; ALUOp = 0;
    tick();
    chk("alu_wrap", ALUOut, 16'h0000);
    idle();

    // Single-cycle push.
    ALUSrcA = 2; ALUSrcB = 1; ALUOp = 1; SPSrc = 1; SPWrite = 1; MemData = 1; PCOut = 16'h0123;
    #1;
    chk("push_din", din, 16'h0123);
    tick();
    chk("push_sp", SPOut, 16'h03FD);
    idle();

    // Branches.
    load_acc(16'h0000);
    BranchCycle = 1; BranchCond = 0; #1;
    chk("br_eqz", {15'd0, DoBranch}, 16'd1);
    BranchCond = 1; #1;
    chk("br_nez", {15'd0, DoBranch}, 16'd0);
    BranchCycle = 0;
    load_acc(16'h8000);
    BranchCycle = 1; BranchCond = 2; #1;
    chk("br_neg", {15'd0, DoBranch}, 16'd1);
    BranchCycle = 0; BranchCond = 3; #1;
    chk("br_nocycle", {15'd0, DoBranch}, 16'd0);
    load_acc(16'h0000);
    BranchCycle = 1; BranchCond = 0; ACCWrite = 1; ACCSrc = 3; InPort = 16'h0005; #1;
    chk("br_preedge", {15'd0, DoBranch}, 16'd1);
    tick();
    chk("br_accload", ACCOut, 16'h0005);
    idle();

    // ACC write with OutWrite stores old ACC.
    ACCWrite = 1; ACCSrc = 3; InPort = 16'h0009; OutWrite = 1;
    tick();
    chk("out_oldacc", OutPort, 16'h0005);
    idle();

    // PCin sources and reset during a write.
    PCSrc = 2; PCOut = 16'h1234; IROut = 16'h0056; #1;
    chk("pcin_page", PCin, 16'h1256);
    idle();
    DataOut = 16'hBEEF; MemOutWrite = 1;
    tick();
    idle();
    PCSrc = 3; #1;
    chk("pcin_mdr", PCin, 16'hBEEF);
    reset = 1; ACCWrite = 1; ACCSrc = 3; InPort = 16'h0007;
    tick();
    chk("rst_accwrite", ACCOut, 16'h0000);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      IROut       = 16'($urandom); PCOut = 16'($urandom);
      DataOut     = 16'($urandom); InPort = 16'($urandom);
      MemOutWrite = 1'($urandom); ACCWrite = 1'($urandom); SPWrite = 1'($urandom);
      SignExt     = 1'($urandom); SPSrc = 1'($urandom); BranchCycle = 1'($urandom);
      MemData     = 1'($urandom); OutWrite = 1'($urandom);
      ALUSrcA     = 2'($urandom); ALUSrcB = 2'($urandom); ACCSrc = 2'($urandom);
      PCSrc       = 2'($urandom); BranchCond = 2'($urandom); ALUOp = 3'($urandom);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
